// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: STAGES slices, one slice resolved per stage,
// slice carry registered between stages, valid/ready handshake with flush.

module cla_slice #(
    parameter int S     = 16,
    parameter int BLOCK = 4
) (
    input  logic [S-1:0] a_i,
    input  logic [S-1:0] b_i,
    input  logic         cin_i,
    output logic [S-1:0] sum_o,
    output logic         cout_o
);
    logic [BLOCK-1:0] g, p;
    logic             grp_g, grp_p, c, bc;

    // Group G/P skip the carry across each BLOCK; bit carries are resolved inside the group.
    always_comb begin
        sum_o = '0;
        g     = '0;
        p     = '0;
        grp_g = 1'b0;
        grp_p = 1'b0;
        bc    = 1'b0;
        c     = cin_i;
        for (int j = 0; j < S / BLOCK; j++) begin
            g     = a_i[j*BLOCK +: BLOCK] & b_i[j*BLOCK +: BLOCK];
            p     = a_i[j*BLOCK +: BLOCK] ^ b_i[j*BLOCK +: BLOCK];
            grp_g = 1'b0;
            grp_p = 1'b1;
            for (int i = 0; i < BLOCK; i++) begin
                grp_g = g[i] | (p[i] & grp_g);
                grp_p = grp_p & p[i];
            end
            bc = c;
            for (int i = 0; i < BLOCK; i++) begin
                sum_o[j*BLOCK+i] = p[i] ^ bc;
                bc               = g[i] | (p[i] & bc);
            end
            c = grp_g | (grp_p & c);
        end
        cout_o = c;
    end
endmodule

module cla_pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);
    localparam int S    = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    if (STAGES < 1 || STAGES > WIDTH / BLOCK || (WIDTH % (STAGES * BLOCK)) != 0) begin : g_bad_cfg
        $error("cla_pipe_adder: WIDTH must be a multiple of STAGES*BLOCK, STAGES in 1..WIDTH/BLOCK");
    end

    logic [STAGES-1:0]             v_q, v_d, adv, load;
    logic [STAGES-1:0][WIDTH-1:0]  a_q, bx_q, sum_q;
    logic [STAGES-1:0]             c_q;
    logic [STAGES-1:0][TAG_W-1:0]  tag_q;
    logic                          ovf_q, zero_q, ovf_d, zero_d;

    logic [STAGES-1:0][WIDTH-1:0]  st_a, st_bx, st_sum, nsum;
    logic [STAGES-1:0]             st_cin, slice_c;
    logic [STAGES-1:0][TAG_W-1:0]  st_tag;
    logic [STAGES-1:0][S-1:0]      slice_sum;
    logic                          room;

    // Stage inputs: stage 0 takes the ports (B pre-inverted for subtract), later stages the previous regs.
    always_comb begin
        st_a[0]   = in_a;
        st_bx[0]  = in_sub ? ~in_b : in_b;
        st_sum[0] = '0;
        st_cin[0] = in_sub | in_cin;
        st_tag[0] = in_tag;
        for (int k = 1; k < STAGES; k++) begin
            st_a[k]   = a_q[k-1];
            st_bx[k]  = bx_q[k-1];
            st_sum[k] = sum_q[k-1];
            st_cin[k] = c_q[k-1];
            st_tag[k] = tag_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        cla_slice #(.S(S), .BLOCK(BLOCK)) u_slice (
            .a_i   (st_a[k][k*S +: S]),
            .b_i   (st_bx[k][k*S +: S]),
            .cin_i (st_cin[k]),
            .sum_o (slice_sum[k]),
            .cout_o(slice_c[k])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            nsum[k]            = st_sum[k];
            nsum[k][k*S +: S]  = slice_sum[k];
        end
    end

    // Flags only from the fully assembled sum of the final stage.
    assign ovf_d  = (st_a[LAST][WIDTH-1] == st_bx[LAST][WIDTH-1]) &&
                    (nsum[LAST][WIDTH-1] != st_a[LAST][WIDTH-1]);
    assign zero_d = (nsum[LAST] == '0);

    // Ready chain walks back from the output; room = stage k may take a new entry.
    always_comb begin
        room = out_ready;
        adv  = '0;
        load = '0;
        v_d  = '0;
        for (int k = LAST; k >= 0; k--) begin
            adv[k] = v_q[k] & room;
            room   = ~v_q[k] | adv[k];
        end
        in_ready = room & ~flush;
        load[0]  = in_valid & in_ready;
        for (int k = 1; k < STAGES; k++) load[k] = adv[k-1];
        for (int k = 0; k < STAGES; k++) v_d[k] = ~flush & (load[k] | (v_q[k] & ~adv[k]));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v_q    <= '0;
            a_q    <= '0;
            bx_q   <= '0;
            sum_q  <= '0;
            c_q    <= '0;
            tag_q  <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b1;
        end else begin
            v_q <= v_d;
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    a_q[k]   <= st_a[k];
                    bx_q[k]  <= st_bx[k];
                    sum_q[k] <= nsum[k];
                    c_q[k]   <= slice_c[k];
                    tag_q[k] <= st_tag[k];
                end
            end
            if (load[LAST]) begin
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end

    // Finished low operand slices and the last stage's operand copies are dead.
    logic unused_bits;
    assign unused_bits = ^{st_a, st_bx, a_q, bx_q};

    assign out_valid = v_q[LAST];
    assign out_sum   = sum_q[LAST];
    assign out_cout  = c_q[LAST];
    assign out_ovf   = ovf_q;
    assign out_zero  = zero_q;
    assign out_tag   = tag_q[LAST];
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed bench for cla_pipe_adder (WIDTH=32, BLOCK=4, STAGES=2).
module tb_cla_pipe_adder;
    localparam int W  = 32;
    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          resetn, flush, in_valid, in_ready, in_sub, in_cin;
    logic          out_valid, out_ready, out_cout, out_ovf, out_zero;
    logic [W-1:0]  in_a, in_b, out_sum;
    logic [TW-1:0] in_tag, out_tag;
    int            errs = 0;
    int            checks = 0;

    always #5 clk = ~clk;

    cla_pipe_adder #(.WIDTH(W), .BLOCK(4), .STAGES(2), .TAG_W(TW)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_sub(in_sub), .in_cin(in_cin), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero), .out_tag(out_tag)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic cin, input logic [TW-1:0] tag);
        in_valid = v; in_a = a; in_b = b; in_sub = sub; in_cin = cin; in_tag = tag;
    endtask

    task automatic test_reset();
        resetn = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
        #12;
        checks++;
        if (out_valid !== 1'b0) begin
            errs++; $display("FAIL reset_valid: got %b want 0", out_valid);
        end
        checks++;
        if ({out_sum, out_cout, out_ovf, out_zero, out_tag} !== {32'h0, 1'b0, 1'b0, 1'b1, 5'h0}) begin
            errs++;
            $display("FAIL reset_outputs: got sum=%h c=%b o=%b z=%b tag=%0d want 0 0 0 1 0",
                     out_sum, out_cout, out_ovf, out_zero, out_tag);
        end
        @(negedge clk);
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_arith();
        logic [W-1:0] ta [8] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h5,
                                 32'h80000000, 32'h5, 32'h12345678, 32'h0000FFFF};
        logic [W-1:0] tb [8] = '{32'h1, 32'h1, 32'h1, 32'h7, 32'h1, 32'h5, 32'h0EDCBA98, 32'h1};
        logic         ts [8] = '{0, 0, 0, 1, 1, 1, 0, 0};
        logic         tc [8] = '{0, 0, 1, 0, 0, 1, 1, 0};
        logic [W-1:0] es [8] = '{32'h80000000, 32'h0, 32'h1, 32'hFFFFFFFE,
                                 32'h7FFFFFFF, 32'h0, 32'h21111111, 32'h00010000};
        logic         ec [8] = '{0, 1, 1, 0, 1, 1, 0, 0};
        logic         eo [8] = '{1, 0, 0, 0, 1, 0, 0, 0};
        logic         ez [8] = '{0, 1, 0, 0, 0, 1, 0, 0};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, ta[i], tb[i], ts[i], tc[i], 5'(i));
            tick();
            drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
            checks++;
            if (out_valid !== 1'b0) begin
                errs++; $display("FAIL arith_latency[%0d]: out_valid=%b after 1 cycle want 0", i, out_valid);
            end
            tick();
            checks++;
            if ({out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag} !==
                {1'b1, es[i], ec[i], eo[i], ez[i], 5'(i)}) begin
                errs++;
                $display("FAIL arith[%0d]: got v=%b sum=%h c=%b o=%b z=%b tag=%0d want 1 %h %b %b %b %0d",
                         i, out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag,
                         es[i], ec[i], eo[i], ez[i], i);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0, got = 0;
        bit stalled = 0, saw_full = 0;
        logic [W+TW+2:0] snap = '0;
        logic [W-1:0] ea;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            drive(sent < 6, 32'hF0000000 + 32'(sent) * 32'h01010101, 32'h10000000 + 32'(sent),
                  1'b0, 1'b0, 5'(sent));
            out_ready = !(cyc >= 3 && cyc <= 5);
            #1;
            if (!in_ready && sent < 6) saw_full = 1;
            if (stalled) begin
                checks++;
                if ({out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag} !== {1'b1, snap}) begin
                    errs++;
                    $display("FAIL b2b_stable cyc%0d: got v=%b sum=%h tag=%0d want held sum=%h tag=%0d",
                             cyc, out_valid, out_sum, out_tag, snap[W+TW+2:TW+3], snap[TW-1:0]);
                end
            end
            if (out_valid && out_ready) begin
                ea = 32'hF0000000 + 32'(got) * 32'h01010101 + 32'h10000000 + 32'(got);
                checks++;
                if (out_tag !== 5'(got) || out_sum !== ea) begin
                    errs++;
                    $display("FAIL b2b_order #%0d: got tag=%0d sum=%h want tag=%0d sum=%h",
                             got, out_tag, out_sum, got, ea);
                end
                got++;
            end
            stalled = out_valid && !out_ready;
            snap = {out_sum, out_cout, out_ovf, out_zero, out_tag};
            if (in_valid && in_ready) sent++;
            tick();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
        out_ready = 1'b1;
        checks++;
        if (got != 6 || sent != 6) begin
            errs++; $display("FAIL b2b_count: got %0d sent %0d want 6 6", got, sent);
        end
        checks++;
        if (!saw_full) begin
            errs++; $display("FAIL b2b_ready_drop: in_ready never 0 while full, want drop");
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errs++; $display("FAIL b2b_dup: out_valid=%b after all consumed want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        int bad = 0;
        out_ready = 1'b0;
        drive(1'b1, 32'h11, 32'h22, 1'b0, 1'b0, 5'd10);
        tick();
        drive(1'b1, 32'h33, 32'h44, 1'b0, 1'b0, 5'd11);
        tick();
        flush = 1'b1;
        drive(1'b1, 32'h55, 32'h66, 1'b0, 1'b0, 5'd12);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errs++; $display("FAIL flush_ready: in_ready=%b during flush want 0", in_ready);
        end
        tick();
        flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            if (out_valid !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errs++; $display("FAIL flush_kill: out_valid high %0d cycles after flush want 0", bad);
        end
        drive(1'b1, 32'hFFFF0000, 32'h00010000, 1'b0, 1'b1, 5'd13);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errs++; $display("FAIL flush_accept: in_ready=%b want 1", in_ready);
        end
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
        tick();
        checks++;
        if ({out_valid, out_sum, out_cout, out_zero, out_tag} !== {1'b1, 32'h00000001, 1'b1, 1'b0, 5'd13}) begin
            errs++;
            $display("FAIL flush_next: got v=%b sum=%h c=%b z=%b tag=%0d want 1 00000001 1 0 13",
                     out_valid, out_sum, out_cout, out_zero, out_tag);
        end
        tick();
    endtask

    task automatic test_async_reset();
        int bad = 0;
        out_ready = 1'b0;
        drive(1'b1, 32'h0000ABCD, 32'h1, 1'b0, 1'b0, 5'd7);
        tick();
        drive(1'b1, 32'h2, 32'h3, 1'b0, 1'b0, 5'd8);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
        checks++;
        if (out_valid !== 1'b1 || out_tag !== 5'd7) begin
            errs++; $display("FAIL rst_pre: got v=%b tag=%0d want 1 7", out_valid, out_tag);
        end
        #3;
        resetn = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag} !==
            {1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 5'h0}) begin
            errs++;
            $display("FAIL rst_async: got v=%b sum=%h c=%b o=%b z=%b tag=%0d want 0 0 0 0 1 0",
                     out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag);
        end
        #2;
        resetn = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (out_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errs++; $display("FAIL rst_no_partial: out_valid high %0d cycles after release want 0", bad);
        end
    endtask

    task automatic test_stream();
        localparam int N = 300;
        logic [W+TW+2:0] q [$];
        logic [W+TW+2:0] exp_v, act_v;
        logic [W-1:0] a, b, s;
        logic sub, cin, co, ov;
        longint sr;
        int sent = 0, got = 0;
        bit pend = 0;
        a = '0; b = '0; sub = 0; cin = 0;
        for (int cyc = 0; cyc < 3000 && got < N; cyc++) begin
            if (!pend && sent < N) begin
                a    = ($urandom_range(7) == 0) ? 32'hFFFFFFFF : $urandom;
                b    = ($urandom_range(7) == 0) ? 32'h80000000 : $urandom;
                sub  = 1'($urandom_range(1));
                cin  = 1'($urandom_range(1));
                pend = ($urandom_range(3) != 0);
            end
            drive(pend, a, b, sub, cin, 5'(sent));
            out_ready = ($urandom_range(3) != 0);
            #1;
            if (out_valid && out_ready) begin
                act_v = {out_sum, out_cout, out_ovf, out_zero, out_tag};
                checks++;
                if (q.size() == 0) begin
                    errs++; $display("FAIL stream_extra: unexpected result sum=%h tag=%0d", out_sum, out_tag);
                end else begin
                    exp_v = q.pop_front();
                    if (act_v !== exp_v) begin
                        errs++;
                        $display("FAIL stream #%0d: got %h want %h (sum,c,o,z,tag)", got, act_v, exp_v);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                if (sub) begin
                    s  = a - b;
                    co = (a >= b);
                    sr = longint'($signed(a)) - longint'($signed(b));
                end else begin
                    s  = a + b + 32'(cin);
                    co = ({1'b0, a} + {1'b0, b} + {32'b0, cin}) > 33'hFFFFFFFF;
                    sr = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
                end
                ov = (sr != longint'($signed(s)));
                q.push_back({s, co, ov, (s == 32'h0), 5'(sent)});
                sent++;
                pend = 0;
            end
            tick();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
        checks++;
        if (got != N) begin
            errs++; $display("FAIL stream_timeout: got %0d results want %0d", got, N);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_stream();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
